// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and hold-buffer state type for the writeback arbiter
package regfile_pkg;

  localparam int W = 8;
  localparam int N = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - requester handshakes, register-file write port and decode snoop
interface regfile_wr_arbiter_if
  import regfile_pkg::*;
  ();

  logic         req0_valid;
  logic [N-1:0] req0_reg;
  logic [W-1:0] req0_data;
  logic         req0_ready;

  logic         req1_valid;
  logic [N-1:0] req1_reg;
  logic [W-1:0] req1_data;
  logic         req1_ready;

  logic         write;
  logic [N-1:0] wreg;
  logic [W-1:0] wdata;

  logic [N-1:0] rreg1;
  logic [N-1:0] rreg2;
  logic         rd1_pend;
  logic         rd2_pend;

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    input  rreg1, rreg2,
    output req0_ready, req1_ready,
    output write, wreg, wdata,
    output rd1_pend, rd2_pend
  );

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    output rreg1, rreg2,
    input  req0_ready, req1_ready,
    input  write, wreg, wdata,
    input  rd1_pend, rd2_pend
  );

endinterface

// File: rtl/wb_hold_buffer.sv
// rtl/wb_hold_buffer.sv - single-entry writeback hold buffer; load wins over drain on the same edge
module wb_hold_buffer
  import regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         drain,
  input  logic [N-1:0] load_reg,
  input  logic [W-1:0] load_data,
  output logic         hold_valid,
  output logic [N-1:0] hold_reg,
  output logic [W-1:0] hold_data
);

  hold_state_t  state_q, state_d;
  logic [N-1:0] reg_q, reg_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      reg_d   = load_reg;
      data_d  = load_data;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  assign hold_valid = (state_q == FULL);
  assign hold_reg   = reg_q;
  assign hold_data  = data_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter sharing the register-file write port between ALU and load writeback
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  regfile_wr_arbiter_if.slave   bus
);

  logic         v0, v1;
  logic [N-1:0] r0, r1;
  logic [W-1:0] d0, d1;
  logic         grant0, grant1;
  logic         acc0, acc1;
  logic         rr_last_q, rr_last_d;
  logic         age_q, age_d;

  wb_hold_buffer u_hold0 (
    .clk       (clk),
    .reset     (reset),
    .load      (acc0),
    .drain     (grant0),
    .load_reg  (bus.req0_reg),
    .load_data (bus.req0_data),
    .hold_valid(v0),
    .hold_reg  (r0),
    .hold_data (d0)
  );

  wb_hold_buffer u_hold1 (
    .clk       (clk),
    .reset     (reset),
    .load      (acc1),
    .drain     (grant1),
    .load_reg  (bus.req1_reg),
    .load_data (bus.req1_data),
    .hold_valid(v1),
    .hold_reg  (r1),
    .hold_data (d1)
  );

  // Same destination must commit oldest-first; otherwise alternate away from the last winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (v0 && v1) begin
      if (r0 == r1) begin
        grant0 = !age_q;
        grant1 = age_q;
      end else begin
        grant0 = rr_last_q;
        grant1 = !rr_last_q;
      end
    end else begin
      grant0 = v0;
      grant1 = v1;
    end
  end

  assign bus.req0_ready = !v0 || grant0;
  assign bus.req1_ready = !v1 || grant1;
  assign acc0 = bus.req0_valid && bus.req0_ready;
  assign acc1 = bus.req1_valid && bus.req1_ready;

  assign bus.write = v0 | v1;
  assign bus.wreg  = grant0 ? r0 : (grant1 ? r1 : '0);
  assign bus.wdata = grant0 ? d0 : (grant1 ? d1 : '0);

  assign bus.rd1_pend = (v0 && (r0 == bus.rreg1)) || (v1 && (r1 == bus.rreg1));
  assign bus.rd2_pend = (v0 && (r0 == bus.rreg2)) || (v1 && (r1 == bus.rreg2));

  always_comb begin
    rr_last_d = rr_last_q;
    if (grant0) begin
      rr_last_d = 1'b0;
    end else if (grant1) begin
      rr_last_d = 1'b1;
    end
  end

  // age = 1 means entry 1 is older; a fresh load behind a still-full partner is the younger.
  always_comb begin
    age_d = age_q;
    if (acc0 && acc1) begin
      age_d = 1'b0;
    end else if (acc0 && v1 && !grant1) begin
      age_d = 1'b1;
    end else if (acc1 && v0 && !grant0) begin
      age_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q <= 1'b1;
      age_q     <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
      age_q     <= age_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed and random checks of the writeback arbiter against a queue-based model
module tb_regfile_wr_arbiter;

  logic clk = 1'b1;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0] r;
    logic [7:0] d;
    int         c;
  } pend_t;

  pend_t      q[$];
  logic [7:0] rf[32];
  logic [7:0] exp_rf[32];
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         tot_cnt = 0;
  int         ncyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    if ($urandom_range(0, 3) == 0) r = 5'($urandom_range(0, 3));
    else r = 5'($urandom_range(0, 31));
    return r;
  endfunction

  // Reference: writes to one register commit in acceptance order (req0 before req1 on a tie),
  // each within 1..2 cycles of acceptance; anything held at reset is lost.
  always @(negedge clk) begin : tracker
    int  idx;
    bit  found;
    ncyc++;
    if (!reset) begin
      q.delete();
    end else begin
      if (bus.write) begin
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < q.size(); i++) begin
          if (!found && q[i].r == bus.wreg) begin
            found = 1'b1;
            idx = i;
          end
        end
        chk("commit_known", {31'd0, found}, 32'd1);
        if (found) begin
          chk("commit_data", {24'd0, bus.wdata}, {24'd0, q[idx].d});
          chk("commit_latency", {31'd0, ((ncyc - q[idx].c) >= 1) && ((ncyc - q[idx].c) <= 2)}, 32'd1);
          q.delete(idx);
        end
        rf[bus.wreg] = bus.wdata;
      end
      if (bus.req0_valid && bus.req0_ready) begin
        q.push_back('{r: bus.req0_reg, d: bus.req0_data, c: ncyc});
        exp_rf[bus.req0_reg] = bus.req0_data;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        q.push_back('{r: bus.req1_reg, d: bus.req1_data, c: ncyc});
        exp_rf[bus.req1_reg] = bus.req1_data;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = 8'd0;
      exp_rf[i] = 8'd0;
    end
    bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
    bus.rreg1 = '0; bus.rreg2 = '0;

    #15;
    reset = 1'b1;
    #1;
    chk("rst_write", {31'd0, bus.write}, 32'd0);
    chk("rst_wreg", {27'd0, bus.wreg}, 32'd0);
    chk("rst_wdata", {24'd0, bus.wdata}, 32'd0);
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd1);
    chk("rst_pend1", {31'd0, bus.rd1_pend}, 32'd0);
    chk("rst_pend2", {31'd0, bus.rd2_pend}, 32'd0);

    // Reset during a held write drops it
    tick();
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd5; bus.req0_data = 8'h3C;
    tick();
    bus.req0_valid = 1'b0;
    chk("midrst_write_before", {31'd0, bus.write}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_write_drop", {31'd0, bus.write}, 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("midrst_reg5", {24'd0, rf[5]}, 32'd0);

    // Single requester
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd7; bus.req0_data = 8'hA5;
    tick();
    bus.req0_valid = 1'b0;
    chk("single_write", {31'd0, bus.write}, 32'd1);
    chk("single_wreg", {27'd0, bus.wreg}, 32'd7);
    chk("single_wdata", {24'd0, bus.wdata}, 32'hA5);
    tick(); tick();
    chk("single_rf7", {24'd0, rf[7]}, 32'hA5);

    // Back-to-back from requester 0
    for (int k = 1; k <= 3; k++) begin
      bus.req0_valid = 1'b1; bus.req0_reg = 5'(k); bus.req0_data = 8'(k * 17);
      chk("b2b_ready", {31'd0, bus.req0_ready}, 32'd1);
      tick();
      chk("b2b_wreg", {27'd0, bus.wreg}, 32'(k));
      chk("b2b_wdata", {24'd0, bus.wdata}, 32'(k * 17));
    end
    bus.req0_valid = 1'b0;
    tick(); tick();
    chk("b2b_rf1", {24'd0, rf[1]}, 32'h11);
    chk("b2b_rf2", {24'd0, rf[2]}, 32'h22);
    chk("b2b_rf3", {24'd0, rf[3]}, 32'h33);

    // Contention: fresh reset so requester 0 wins first
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd3; bus.req0_data = 8'h10;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd4; bus.req1_data = 8'h20;
    tick();
    chk("cont_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("cont_ready1", {31'd0, bus.req1_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("cont_wreg", {27'd0, bus.wreg}, (k % 2 == 1) ? 32'd4 : 32'd3);
      chk("cont_wdata", {24'd0, bus.wdata}, (k % 2 == 1) ? 32'h20 : 32'h10);
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick(); tick(); tick();

    // Same register, same edge: req1's value lands last
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd9; bus.req0_data = 8'h01;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd9; bus.req1_data = 8'h02;
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("same_first", {24'd0, bus.wdata}, 32'h01);
    tick();
    chk("same_second", {24'd0, bus.wdata}, 32'h02);
    tick(); tick();
    chk("same_rf9", {24'd0, rf[9]}, 32'h02);

    // Same register, req1 first then req0
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd9; bus.req1_data = 8'h02;
    tick();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd9; bus.req0_data = 8'h01;
    chk("seq_first", {24'd0, bus.wdata}, 32'h02);
    tick();
    bus.req0_valid = 1'b0;
    chk("seq_second", {24'd0, bus.wdata}, 32'h01);
    tick(); tick();
    chk("seq_rf9", {24'd0, rf[9]}, 32'h01);

    // Pending flags
    bus.rreg1 = 5'd12; bus.rreg2 = 5'd13;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd12; bus.req1_data = 8'h77;
    tick();
    bus.req1_valid = 1'b0;
    chk("pend_rd1_hit", {31'd0, bus.rd1_pend}, 32'd1);
    chk("pend_rd2_miss", {31'd0, bus.rd2_pend}, 32'd0);
    tick();
    chk("pend_rd1_clear", {31'd0, bus.rd1_pend}, 32'd0);
    chk("pend_rd2_clear", {31'd0, bus.rd2_pend}, 32'd0);
    tick();

    // Random soak: last write per register wins
    for (int i = 0; i < 32; i++) begin
      rf[i] = 8'd0;
      exp_rf[i] = 8'd0;
    end
    for (int it = 0; it < 1000; it++) begin
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req0_reg = pick_reg();
      bus.req0_data = 8'($urandom_range(0, 255));
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.req1_reg = pick_reg();
      bus.req1_data = 8'($urandom_range(0, 255));
      bus.rreg1 = 5'($urandom_range(0, 31));
      bus.rreg2 = 5'($urandom_range(0, 31));
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("soak_drained", 32'(q.size()), 32'd0);
    chk("soak_idle_write", {31'd0, bus.write}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("soak_rf%0d", i), {24'd0, rf[i]}, {24'd0, exp_rf[i]});
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
